execute_stage: RTL and testbench
================================

EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 Parameters SHALL be: DWIDTH, 32, data width; PC_WIDTH, 32, PC width; AWIDTH, 5, register address width; FUNCT_WIDTH, 3, funct3 width.
REQ-002 ex_clk  in  1  single clock; all state updates on its rising edge.
REQ-003 ex_rst  in  1  reset, synchronous, active-high.
REQ-004 ex_i_ce  in  1  decoded instruction valid this cycle.
REQ-005 ex_i_stall  in  1  downstream stall; ex_i_flush  in  1  discard held and incoming instruction.
REQ-006 ex_i_opcode  in  11  one-hot: 0 RTYPE, 1 ITYPE, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC, 9 SYSTEM, 10 FENCE.
REQ-007 ex_i_alu  in  14  one-hot: 0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 XOR, 5 OR, 6 AND, 7 SLL, 8 SRL, 9 SRA, 10 EQ, 11 NEQ, 12 GE, 13 GEU.
REQ-008 ex_i_funct3 FUNCT_WIDTH, ex_i_imm DWIDTH, ex_i_pc PC_WIDTH, ex_i_rs1_data DWIDTH, ex_i_rs2_data DWIDTH, ex_i_addr_rd AWIDTH: inputs from decode.
REQ-009 ex_o_ce  out  1  registered result valid; ex_o_result  out  DWIDTH  ALU/link result.
REQ-010 ex_o_rs2_data DWIDTH, ex_o_addr_rd AWIDTH, ex_o_funct3 FUNCT_WIDTH, ex_o_opcode 11: registered pass-through outputs.
REQ-011 ex_o_we_rd  out  1  register write enable for writeback.
REQ-012 ex_o_change_pc  out  1  redirect request; ex_o_next_pc  out  PC_WIDTH  redirect target.
REQ-013 ex_o_stall  out  1  upstream stall; ex_o_flush  out  1  upstream flush.

Function
REQ-014 Operand A SHALL be ex_i_pc for AUIPC/JAL/JALR-link, 0 for LUI, else ex_i_rs1_data.
REQ-015 Operand B SHALL be ex_i_rs2_data for RTYPE/BRANCH, else ex_i_imm.
REQ-016 ALU ops: ADD/SUB modulo 2^DWIDTH; SLT signed, SLTU unsigned, result 0/1; shifts use B[4:0]; SRA sign-fills; EQ/NEQ/GE(signed)/GEU yield 0/1.
REQ-017 Result SHALL be ex_i_pc+4 for JAL/JALR, A+imm for LUI/AUIPC, else ALU output.
REQ-018 Branch taken SHALL be BRANCH and compare output =1; JAL/JALR SHALL always redirect.
REQ-019 Target SHALL be ex_i_pc+ex_i_imm for BRANCH/JAL; (ex_i_rs1_data+ex_i_imm) with bit 0 cleared for JALR.
REQ-020 ex_o_we_rd SHALL be 1 only for valid RTYPE/ITYPE/LOAD/JAL/JALR/LUI/AUIPC with ex_i_addr_rd != 0.
REQ-021 Latency: one cycle; capture on edge when ex_i_ce=1, ex_i_stall=0, ex_i_flush=0, ex_o_change_pc=0.
REQ-022 ex_i_ce=0 (no stall): ex_o_ce, ex_o_we_rd, ex_o_change_pc SHALL clear next edge; data outputs don't-care.
REQ-023 ex_i_stall=1: all outputs SHALL hold; ex_o_stall SHALL equal ex_i_stall combinationally.
REQ-024 ex_i_flush=1: ex_o_ce, ex_o_we_rd, ex_o_change_pc SHALL clear next edge; flush overrides stall.
REQ-025 ex_o_change_pc SHALL be a one-cycle pulse registered with the branch/jump; ex_o_flush SHALL equal ex_o_change_pc.
REQ-026 While ex_o_change_pc=1, the incoming instruction SHALL be squashed (ex_o_ce=0 next cycle).
REQ-027 Redirect with ex_i_stall=1 SHALL hold ex_o_change_pc high until stall drops, then pulse clears.

Reset
REQ-028 ex_rst=1 at an edge SHALL zero all registered outputs, overriding ce, stall and flush.
REQ-029 Reset mid-operation SHALL drop the held instruction; first post-reset capture is the next valid input.

Verification
REQ-030 RTYPE ADD rs1=5, rs2=7, rd=3 -> next cycle ex_o_ce=1, ex_o_result=12, ex_o_addr_rd=3, ex_o_we_rd=1.
REQ-031 ITYPE SRA rs1=0xFFFFFFF0, imm=4 -> ex_o_result=0xFFFFFFFF; SLTU rs1=1, imm=0xFFFFFFFF -> 1; SLT -> 0.
REQ-032 BRANCH EQ pc=0x40, rs1=rs2=9, imm=0x10 -> ex_o_change_pc=1, ex_o_flush=1, ex_o_next_pc=0x50, ex_o_we_rd=0; following input squashed.
REQ-033 JALR pc=0x100, rs1=0x203, imm=4, rd=1 -> ex_o_next_pc=0x206, ex_o_result=0x104, ex_o_we_rd=1; rd=0 -> ex_o_we_rd=0.
REQ-034 ADD captured, stall 3 cycles with new inputs -> outputs unchanged; stall+flush -> ex_o_ce=0 next edge.
REQ-035 ex_rst=1 one cycle while valid branch held -> all outputs 0 next edge, no redirect pulse.

Source files
------------

// File: rtl/execute_stage.sv
// Execute stage: operand selection, ALU, branch/jump resolution and a single
// output register bank that feeds memory/writeback and redirects fetch.
module execute_stage #(
    parameter int DWIDTH      = 32,
    parameter int PC_WIDTH    = 32,
    parameter int AWIDTH      = 5,
    parameter int FUNCT_WIDTH = 3
) (
    input  logic                   ex_clk,
    input  logic                   ex_rst,
    input  logic                   ex_i_ce,
    input  logic                   ex_i_stall,
    input  logic                   ex_i_flush,
    input  logic [10:0]            ex_i_opcode,
    input  logic [13:0]            ex_i_alu,
    input  logic [FUNCT_WIDTH-1:0] ex_i_funct3,
    input  logic [DWIDTH-1:0]      ex_i_imm,
    input  logic [PC_WIDTH-1:0]    ex_i_pc,
    input  logic [DWIDTH-1:0]      ex_i_rs1_data,
    input  logic [DWIDTH-1:0]      ex_i_rs2_data,
    input  logic [AWIDTH-1:0]      ex_i_addr_rd,
    output logic                   ex_o_ce,
    output logic [DWIDTH-1:0]      ex_o_result,
    output logic [DWIDTH-1:0]      ex_o_rs2_data,
    output logic [AWIDTH-1:0]      ex_o_addr_rd,
    output logic [FUNCT_WIDTH-1:0] ex_o_funct3,
    output logic [10:0]            ex_o_opcode,
    output logic                   ex_o_we_rd,
    output logic                   ex_o_change_pc,
    output logic [PC_WIDTH-1:0]    ex_o_next_pc,
    output logic                   ex_o_stall,
    output logic                   ex_o_flush
);

    localparam int OP_RTYPE  = 0;
    localparam int OP_BRANCH = 4;
    localparam int OP_JAL    = 5;
    localparam int OP_JALR   = 6;
    localparam int OP_LUI    = 7;
    localparam int OP_AUIPC  = 8;

    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_XOR  = 4;
    localparam int ALU_OR   = 5;
    localparam int ALU_AND  = 6;
    localparam int ALU_SLL  = 7;
    localparam int ALU_SRL  = 8;
    localparam int ALU_SRA  = 9;
    localparam int ALU_EQ   = 10;
    localparam int ALU_NEQ  = 11;
    localparam int ALU_GE   = 12;
    localparam int ALU_GEU  = 13;

    // RTYPE, ITYPE, LOAD, JAL, JALR, LUI, AUIPC write a destination register
    localparam logic [10:0] WB_MASK = 11'b001_1110_0111;

    // Zero-extended 0/1 word for compare results
    function automatic logic [DWIDTH-1:0] flag_word(input logic f);
        return {{(DWIDTH-1){1'b0}}, f};
    endfunction

    logic [DWIDTH-1:0]   op_a_s;
    logic [DWIDTH-1:0]   op_b_s;
    logic [4:0]          shamt_s;
    logic [DWIDTH-1:0]   alu_out_s;
    logic [DWIDTH-1:0]   result_s;
    logic [DWIDTH-1:0]   jalr_sum_s;
    logic [PC_WIDTH-1:0] target_s;
    logic                is_jump_s;
    logic                change_pc_s;
    logic                we_rd_s;

    logic                   ce_r;
    logic [DWIDTH-1:0]      result_r;
    logic [DWIDTH-1:0]      rs2_data_r;
    logic [AWIDTH-1:0]      addr_rd_r;
    logic [FUNCT_WIDTH-1:0] funct3_r;
    logic [10:0]            opcode_r;
    logic                   we_rd_r;
    logic                   change_pc_r;
    logic [PC_WIDTH-1:0]    next_pc_r;

    assign is_jump_s = ex_i_opcode[OP_JAL] | ex_i_opcode[OP_JALR];
    assign shamt_s   = op_b_s[4:0];

    // Operand selection
    always_comb begin
        op_a_s = ex_i_rs1_data;
        op_b_s = ex_i_imm;
        if (ex_i_opcode[OP_AUIPC] || is_jump_s) begin
            op_a_s = DWIDTH'(ex_i_pc);
        end else if (ex_i_opcode[OP_LUI]) begin
            op_a_s = {DWIDTH{1'b0}};
        end else begin
            op_a_s = ex_i_rs1_data;
        end
        if (ex_i_opcode[OP_RTYPE] || ex_i_opcode[OP_BRANCH]) begin
            op_b_s = ex_i_rs2_data;
        end else begin
            op_b_s = ex_i_imm;
        end
    end

    // ALU; an empty one-hot select yields zero
    always_comb begin
        alu_out_s = {DWIDTH{1'b0}};
        if (ex_i_alu[ALU_ADD])       alu_out_s = op_a_s + op_b_s;
        else if (ex_i_alu[ALU_SUB])  alu_out_s = op_a_s - op_b_s;
        else if (ex_i_alu[ALU_SLT])  alu_out_s = flag_word($signed(op_a_s) < $signed(op_b_s));
        else if (ex_i_alu[ALU_SLTU]) alu_out_s = flag_word(op_a_s < op_b_s);
        else if (ex_i_alu[ALU_XOR])  alu_out_s = op_a_s ^ op_b_s;
        else if (ex_i_alu[ALU_OR])   alu_out_s = op_a_s | op_b_s;
        else if (ex_i_alu[ALU_AND])  alu_out_s = op_a_s & op_b_s;
        else if (ex_i_alu[ALU_SLL])  alu_out_s = op_a_s << shamt_s;
        else if (ex_i_alu[ALU_SRL])  alu_out_s = op_a_s >> shamt_s;
        else if (ex_i_alu[ALU_SRA])  alu_out_s = DWIDTH'($signed(op_a_s) >>> shamt_s);
        else if (ex_i_alu[ALU_EQ])   alu_out_s = flag_word(op_a_s == op_b_s);
        else if (ex_i_alu[ALU_NEQ])  alu_out_s = flag_word(op_a_s != op_b_s);
        else if (ex_i_alu[ALU_GE])   alu_out_s = flag_word($signed(op_a_s) >= $signed(op_b_s));
        else if (ex_i_alu[ALU_GEU])  alu_out_s = flag_word(op_a_s >= op_b_s);
        else                         alu_out_s = {DWIDTH{1'b0}};
    end

    // Result, redirect decision, target and writeback enable
    always_comb begin
        jalr_sum_s = ex_i_rs1_data + ex_i_imm;
        if (is_jump_s) begin
            result_s = DWIDTH'(ex_i_pc + PC_WIDTH'(32'd4));
        end else if (ex_i_opcode[OP_LUI] || ex_i_opcode[OP_AUIPC]) begin
            result_s = op_a_s + ex_i_imm;
        end else begin
            result_s = alu_out_s;
        end
        if (ex_i_opcode[OP_JALR]) begin
            target_s = PC_WIDTH'(jalr_sum_s) & {{(PC_WIDTH-1){1'b1}}, 1'b0};
        end else begin
            target_s = ex_i_pc + PC_WIDTH'(ex_i_imm);
        end
        change_pc_s = is_jump_s |
                      (ex_i_opcode[OP_BRANCH] & (alu_out_s == flag_word(1'b1)));
        we_rd_s     = (|(ex_i_opcode & WB_MASK)) & (ex_i_addr_rd != {AWIDTH{1'b0}});
    end

    // Output register bank: reset > flush > stall > squash/idle > capture
    always_ff @(posedge ex_clk) begin
        if (ex_rst) begin
            ce_r        <= 1'b0;
            result_r    <= {DWIDTH{1'b0}};
            rs2_data_r  <= {DWIDTH{1'b0}};
            addr_rd_r   <= {AWIDTH{1'b0}};
            funct3_r    <= {FUNCT_WIDTH{1'b0}};
            opcode_r    <= 11'd0;
            we_rd_r     <= 1'b0;
            change_pc_r <= 1'b0;
            next_pc_r   <= {PC_WIDTH{1'b0}};
        end else if (ex_i_flush) begin
            ce_r        <= 1'b0;
            we_rd_r     <= 1'b0;
            change_pc_r <= 1'b0;
        end else if (ex_i_stall) begin
            ce_r        <= ce_r;
            we_rd_r     <= we_rd_r;
            change_pc_r <= change_pc_r;
        end else if (change_pc_r || !ex_i_ce) begin
            // the instruction behind a redirect is on the wrong path
            ce_r        <= 1'b0;
            we_rd_r     <= 1'b0;
            change_pc_r <= 1'b0;
        end else begin
            ce_r        <= 1'b1;
            result_r    <= result_s;
            rs2_data_r  <= ex_i_rs2_data;
            addr_rd_r   <= ex_i_addr_rd;
            funct3_r    <= ex_i_funct3;
            opcode_r    <= ex_i_opcode;
            we_rd_r     <= we_rd_s;
            change_pc_r <= change_pc_s;
            next_pc_r   <= target_s;
        end
    end

    assign ex_o_ce        = ce_r;
    assign ex_o_result    = result_r;
    assign ex_o_rs2_data  = rs2_data_r;
    assign ex_o_addr_rd   = addr_rd_r;
    assign ex_o_funct3    = funct3_r;
    assign ex_o_opcode    = opcode_r;
    assign ex_o_we_rd     = we_rd_r;
    assign ex_o_change_pc = change_pc_r;
    assign ex_o_next_pc   = next_pc_r;
    assign ex_o_flush     = change_pc_r;
    assign ex_o_stall     = ex_i_stall;

endmodule

// File: tb/tb_execute_stage.sv
// Directed and random checks of execute_stage against a behavioural model of
// the stage's instruction semantics and pipeline control rules.
module tb_execute_stage;

    logic        ex_clk, ex_rst, ex_i_ce, ex_i_stall, ex_i_flush;
    logic [10:0] ex_i_opcode;
    logic [13:0] ex_i_alu;
    logic [2:0]  ex_i_funct3;
    logic [31:0] ex_i_imm, ex_i_pc, ex_i_rs1_data, ex_i_rs2_data;
    logic [4:0]  ex_i_addr_rd;
    logic        ex_o_ce, ex_o_we_rd, ex_o_change_pc, ex_o_stall, ex_o_flush;
    logic [31:0] ex_o_result, ex_o_rs2_data, ex_o_next_pc;
    logic [4:0]  ex_o_addr_rd;
    logic [2:0]  ex_o_funct3;
    logic [10:0] ex_o_opcode;

    int n_assert = 0;
    int n_fail   = 0;

    // model state
    bit          m_ce, m_we, m_cpc, m_known;
    logic [31:0] m_result, m_rs2, m_npc;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3;
    logic [10:0] m_opc;

    execute_stage dut (
        .ex_clk(ex_clk), .ex_rst(ex_rst), .ex_i_ce(ex_i_ce), .ex_i_stall(ex_i_stall),
        .ex_i_flush(ex_i_flush), .ex_i_opcode(ex_i_opcode), .ex_i_alu(ex_i_alu),
        .ex_i_funct3(ex_i_funct3), .ex_i_imm(ex_i_imm), .ex_i_pc(ex_i_pc),
        .ex_i_rs1_data(ex_i_rs1_data), .ex_i_rs2_data(ex_i_rs2_data),
        .ex_i_addr_rd(ex_i_addr_rd), .ex_o_ce(ex_o_ce), .ex_o_result(ex_o_result),
        .ex_o_rs2_data(ex_o_rs2_data), .ex_o_addr_rd(ex_o_addr_rd),
        .ex_o_funct3(ex_o_funct3), .ex_o_opcode(ex_o_opcode), .ex_o_we_rd(ex_o_we_rd),
        .ex_o_change_pc(ex_o_change_pc), .ex_o_next_pc(ex_o_next_pc),
        .ex_o_stall(ex_o_stall), .ex_o_flush(ex_o_flush)
    );

    initial ex_clk = 1'b0;
    always #5 ex_clk = ~ex_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int onehot_idx(input logic [13:0] v);
        int idx = -1;
        for (int i = 0; i < 14; i++) if (v[i]) idx = i;
        return idx;
    endfunction

    // Instruction semantics computed straight from the rules
    task automatic model_capture();
        int opi = onehot_idx({3'b000, ex_i_opcode});
        int ali = onehot_idx(ex_i_alu);
        logic [31:0] a, b, alu;
        bit link = (opi == 5) || (opi == 6);
        a = (link || opi == 8) ? ex_i_pc : (opi == 7) ? 32'd0 : ex_i_rs1_data;
        b = (opi == 0 || opi == 4) ? ex_i_rs2_data : ex_i_imm;
        case (ali)
            0:  alu = a + b;
            1:  alu = a - b;
            2:  alu = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            3:  alu = (a < b) ? 32'd1 : 32'd0;
            4:  alu = a ^ b;
            5:  alu = a | b;
            6:  alu = a & b;
            7:  alu = a << b[4:0];
            8:  alu = a >> b[4:0];
            9:  alu = 32'(int'(a) >>> b[4:0]);
            10: alu = (a == b) ? 32'd1 : 32'd0;
            11: alu = (a != b) ? 32'd1 : 32'd0;
            12: alu = (int'(a) >= int'(b)) ? 32'd1 : 32'd0;
            13: alu = (a >= b) ? 32'd1 : 32'd0;
            default: alu = 32'd0;
        endcase
        m_ce     = 1;
        m_result = link ? ex_i_pc + 32'd4 : (opi == 7 || opi == 8) ? a + ex_i_imm : alu;
        m_cpc    = link || (opi == 4 && alu == 32'd1);
        m_npc    = (opi == 6) ? ((ex_i_rs1_data + ex_i_imm) & ~32'd1) : ex_i_pc + ex_i_imm;
        m_we     = (opi inside {0, 1, 2, 5, 6, 7, 8}) && (ex_i_addr_rd != 5'd0);
        m_rs2    = ex_i_rs2_data;
        m_rd     = ex_i_addr_rd;
        m_f3     = ex_i_funct3;
        m_opc    = ex_i_opcode;
        m_known  = 1;
    endtask

    task automatic model_edge();
        if (ex_rst) begin
            {m_ce, m_we, m_cpc} = 3'b000;
            m_result = 32'd0; m_rs2 = 32'd0; m_npc = 32'd0;
            m_rd = 5'd0; m_f3 = 3'd0; m_opc = 11'd0; m_known = 1;
        end else if (ex_i_flush || (!ex_i_stall && (m_cpc || !ex_i_ce))) begin
            {m_ce, m_we, m_cpc} = 3'b000;
            m_known = 0;
        end else if (!ex_i_stall) begin
            model_capture();
        end
    endtask

    task automatic tick();
        #1;
        chk("o_stall", 32'(ex_o_stall), 32'(ex_i_stall));
        model_edge();
        @(posedge ex_clk);
        #1;
        chk("o_ce", 32'(ex_o_ce), 32'(m_ce));
        chk("o_we_rd", 32'(ex_o_we_rd), 32'(m_we));
        chk("o_change_pc", 32'(ex_o_change_pc), 32'(m_cpc));
        chk("o_flush", 32'(ex_o_flush), 32'(m_cpc));
        if (m_known) begin
            chk("o_result", ex_o_result, m_result);
            chk("o_rs2_data", ex_o_rs2_data, m_rs2);
            chk("o_addr_rd", 32'(ex_o_addr_rd), 32'(m_rd));
            chk("o_funct3", 32'(ex_o_funct3), 32'(m_f3));
            chk("o_opcode", 32'(ex_o_opcode), 32'(m_opc));
        end
        if (m_cpc) chk("o_next_pc", ex_o_next_pc, m_npc);
    endtask

    task automatic set_instr(input int opi, input int ali, input logic [31:0] pc,
                             input logic [31:0] rs1, input logic [31:0] rs2,
                             input logic [31:0] imm, input logic [4:0] rd);
        ex_i_ce = 1'b1;
        ex_i_opcode = 11'd1 << opi;
        ex_i_alu = 14'd1 << ali;
        ex_i_funct3 = 3'(opi);
        ex_i_pc = pc; ex_i_rs1_data = rs1; ex_i_rs2_data = rs2;
        ex_i_imm = imm; ex_i_addr_rd = rd;
    endtask

    initial begin
        int cmp_ops[6] = '{2, 3, 10, 11, 12, 13};
        ex_rst = 1'b1; ex_i_ce = 1'b0; ex_i_stall = 1'b0; ex_i_flush = 1'b0;
        set_instr(0, 0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
        ex_i_ce = 1'b0;
        tick();
        chk("reset_next_pc", ex_o_next_pc, 32'd0);
        ex_rst = 1'b0;
        tick();

        // RTYPE ADD 5+7 -> x3
        set_instr(0, 0, 32'h0, 32'd5, 32'd7, 32'd0, 5'd3);
        tick();
        chk("add_result", ex_o_result, 32'd12);
        chk("add_we", 32'(ex_o_we_rd), 32'd1);

        // ITYPE SRA / SLTU / SLT
        set_instr(1, 9, 32'h0, 32'hFFFF_FFF0, 32'd0, 32'd4, 5'd4);
        tick();
        chk("sra_result", ex_o_result, 32'hFFFF_FFFF);
        set_instr(1, 3, 32'h0, 32'd1, 32'd0, 32'hFFFF_FFFF, 5'd5);
        tick();
        chk("sltu_result", ex_o_result, 32'd1);
        set_instr(1, 2, 32'h0, 32'd1, 32'd0, 32'hFFFF_FFFF, 5'd5);
        tick();
        chk("slt_result", ex_o_result, 32'd0);

        // taken BEQ, then the following instruction is squashed
        set_instr(4, 10, 32'h40, 32'd9, 32'd9, 32'h10, 5'd0);
        tick();
        chk("beq_change_pc", 32'(ex_o_change_pc), 32'd1);
        chk("beq_next_pc", ex_o_next_pc, 32'h50);
        set_instr(0, 0, 32'h44, 32'd1, 32'd1, 32'd0, 5'd2);
        tick();
        chk("beq_squash_ce", 32'(ex_o_ce), 32'd0);

        // JALR with rd=1 and rd=0
        set_instr(6, 0, 32'h100, 32'h203, 32'd0, 32'd4, 5'd1);
        tick();
        chk("jalr_next_pc", ex_o_next_pc, 32'h206);
        chk("jalr_result", ex_o_result, 32'h104);
        ex_i_ce = 1'b0;
        tick();
        set_instr(6, 0, 32'h100, 32'h203, 32'd0, 32'd4, 5'd0);
        tick();
        chk("jalr_rd0_we", 32'(ex_o_we_rd), 32'd0);
        ex_i_ce = 1'b0;
        tick();

        // capture, stall three cycles with fresh inputs, then stall+flush
        set_instr(0, 0, 32'h0, 32'd100, 32'd23, 32'd0, 5'd7);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_instr(0, 1, $urandom, $urandom, $urandom, $urandom, 5'($urandom));
            ex_i_stall = 1'b1;
            tick();
            chk("stall_hold_result", ex_o_result, 32'd123);
        end
        ex_i_flush = 1'b1;
        tick();
        chk("stall_flush_ce", 32'(ex_o_ce), 32'd0);
        ex_i_flush = 1'b0; ex_i_stall = 1'b0;

        // redirect held through a stall, then released
        set_instr(4, 11, 32'h80, 32'd1, 32'd2, 32'h20, 5'd0);
        tick();
        ex_i_stall = 1'b1;
        tick();
        tick();
        chk("stall_hold_change_pc", 32'(ex_o_change_pc), 32'd1);
        ex_i_stall = 1'b0;
        tick();
        chk("stall_release_change_pc", 32'(ex_o_change_pc), 32'd0);

        // reset while a taken branch is presented, then an idle cycle
        set_instr(4, 10, 32'h40, 32'd9, 32'd9, 32'h10, 5'd0);
        ex_rst = 1'b1;
        tick();
        chk("reset_branch_change_pc", 32'(ex_o_change_pc), 32'd0);
        ex_rst = 1'b0; ex_i_ce = 1'b0;
        tick();
        chk("post_reset_ce", 32'(ex_o_ce), 32'd0);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            int opi = $urandom_range(0, 10);
            int ali = (opi == 4) ? cmp_ops[$urandom_range(0, 5)] : $urandom_range(0, 13);
            logic [31:0] rs1 = $urandom;
            logic [31:0] rs2 = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
            set_instr(opi, ali, $urandom, rs1, rs2, $urandom, 5'($urandom));
            ex_i_funct3 = 3'($urandom_range(0, 7));
            ex_i_ce    = ($urandom_range(0, 3) != 0);
            ex_i_stall = ($urandom_range(0, 4) == 0);
            ex_i_flush = ($urandom_range(0, 15) == 0);
            ex_rst     = ($urandom_range(0, 63) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
